// File: rtl/signed_add_arbiter_if.sv
// Requester and response bundle for the shared signed adder.
// The master side is the client cluster; the slave side is the arbiter.
interface signed_add_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int W       = 4,
   parameter int CNT_W   = 8
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*W-1:0] req_a;
   logic [NUM_REQ*W-1:0] req_b;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [W:0]           rsp_sum;
   logic                 rsp_overflow;
   logic [CNT_W-1:0]     ovf_count;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_overflow, ovf_count
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_overflow, ovf_count
   );
endinterface

// File: rtl/signed_add_arbiter.sv
// Round-robin front end sharing one registered signed adder among NUM_REQ
// requesters; one operation in flight, saturating count of overflowing results.
module signed_add_arbiter_chk #(
   parameter int NUM_REQ = 4,
   parameter int W       = 4,
   parameter int ID_W    = 2
) (
   input logic               clk,
   input logic [NUM_REQ-1:0] req_ready,
   input logic               idle,
   input logic               rsp_valid,
   input logic               rsp_ready,
   input logic [ID_W-1:0]    rsp_id,
   input logic [W:0]         rsp_sum,
   input logic               rsp_overflow
);
   a_grant_onehot: assert property (@(posedge clk) $onehot0(req_ready));

   a_grant_idle: assert property (@(posedge clk) (req_ready != '0) |-> idle);

   // A stalled response must not change under the consumer
   a_rsp_hold: assert property (@(posedge clk)
      (rsp_valid && !rsp_ready) |=>
         (rsp_valid && $stable(rsp_sum) && $stable(rsp_id) && $stable(rsp_overflow)));
endmodule

module signed_add_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int W       = 4,
   parameter int CNT_W   = 8
) (
   input logic                 clk,
   input logic                 rst,
   signed_add_arbiter_if.slave bus
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_r;
   logic [ID_W-1:0]  rr_ptr_r;
   logic [ID_W-1:0]  id_r;
   logic [W-1:0]     a_r;
   logic [W-1:0]     b_r;
   logic             rsp_valid_r;
   logic [ID_W-1:0]  rsp_id_r;
   logic [W:0]       rsp_sum_r;
   logic             rsp_ovf_r;
   logic [CNT_W-1:0] ovf_count_r;

   logic [NUM_REQ-1:0] grant_s;
   logic [ID_W-1:0]    grant_idx_s;
   logic               found_s;
   logic [ID_W:0]      cand_s;
   logic [W-1:0]       a_sel_s;
   logic [W-1:0]       b_sel_s;
   logic [W:0]         sum_s;

   function automatic logic [W:0] sext_add(input logic [W-1:0] a, input logic [W-1:0] b);
      return {a[W-1], a} + {b[W-1], b};
   endfunction

   // The two top bits of the widened sum disagree exactly when W bits cannot hold it
   function automatic logic sum_overflow(input logic [W:0] s);
      return s[W] ^ s[W-1];
   endfunction

   assign sum_s = sext_add(a_r, b_r);

   // Rotating-priority search from just after the last winner, plus operand mux
   always_comb begin
      grant_s     = '0;
      grant_idx_s = '0;
      found_s     = 1'b0;
      cand_s      = '0;
      a_sel_s     = '0;
      b_sel_s     = '0;
      if (state_r == IDLE) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
            if (cand_s >= (ID_W+1)'(NUM_REQ)) begin
               cand_s = cand_s - (ID_W+1)'(NUM_REQ);
            end else begin
               cand_s = cand_s;
            end
            if (!found_s && bus.req_valid[cand_s[ID_W-1:0]]) begin
               found_s     = 1'b1;
               grant_idx_s = cand_s[ID_W-1:0];
            end else begin
               found_s = found_s;
            end
         end
      end else begin
         found_s = 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (found_s && (grant_idx_s == ID_W'(i))) begin
            grant_s[i] = 1'b1;
            a_sel_s    = bus.req_a[i*W +: W];
            b_sel_s    = bus.req_b[i*W +: W];
         end else begin
            grant_s[i] = 1'b0;
         end
      end
   end

   // Operation sequencing, response registers and overflow event counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         rr_ptr_r    <= ID_W'(NUM_REQ - 1);
         id_r        <= '0;
         a_r         <= '0;
         b_r         <= '0;
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= '0;
         rsp_sum_r   <= '0;
         rsp_ovf_r   <= 1'b0;
         ovf_count_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  a_r      <= a_sel_s;
                  b_r      <= b_sel_s;
                  id_r     <= grant_idx_s;
                  rr_ptr_r <= grant_idx_s;
                  state_r  <= EXEC;
               end else begin
                  state_r <= IDLE;
               end
            end
            EXEC: begin
               rsp_sum_r   <= sum_s;
               rsp_ovf_r   <= sum_overflow(sum_s);
               rsp_id_r    <= id_r;
               rsp_valid_r <= 1'b1;
               state_r     <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  state_r     <= IDLE;
                  if (rsp_ovf_r && (ovf_count_r != '1)) begin
                     ovf_count_r <= ovf_count_r + CNT_W'(1);
                  end else begin
                     ovf_count_r <= ovf_count_r;
                  end
               end else begin
                  state_r <= RESP;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready    = grant_s;
   assign bus.rsp_valid    = rsp_valid_r;
   assign bus.rsp_id       = rsp_id_r;
   assign bus.rsp_sum      = rsp_sum_r;
   assign bus.rsp_overflow = rsp_ovf_r;
   assign bus.ovf_count    = ovf_count_r;

   signed_add_arbiter_chk #(
      .NUM_REQ (NUM_REQ),
      .W       (W),
      .ID_W    (ID_W)
   ) u_chk (
      .clk          (clk),
      .req_ready    (grant_s),
      .idle         (state_r == IDLE),
      .rsp_valid    (rsp_valid_r),
      .rsp_ready    (bus.rsp_ready),
      .rsp_id       (rsp_id_r),
      .rsp_sum      (rsp_sum_r),
      .rsp_overflow (rsp_ovf_r)
   );
endmodule

// File: tb/tb_signed_add_arbiter.sv
// Bench for signed_add_arbiter: vector table, scoreboard on the response port,
// and directed sequences for fairness, back-pressure, reset and saturation.
module tb_signed_add_arbiter;
   logic clk;
   logic rst;

   signed_add_arbiter_if #(.NUM_REQ(4), .W(4), .CNT_W(8)) bus ();

   signed_add_arbiter #(.NUM_REQ(4), .W(4), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [1:0] id;
      logic [4:0] sum;
      logic       ovf;
   } exp_t;

   typedef struct {
      int         id;
      logic [3:0] a;
      logic [3:0] b;
      logic [4:0] sum;
      logic       ovf;
   } vec_t;

   exp_t       exp_q[$];
   int         n_chk;
   int         n_fail;
   int         cyc;
   logic [7:0] exp_cnt;
   logic       cnt_chk_en;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic exp_t model(input int id, input logic signed [3:0] a, input logic signed [3:0] b);
      exp_t e;
      int   sa;
      int   sb;
      logic signed [31:0] s;
      sa = a;
      sb = b;
      s = sa + sb;
      e.id  = 2'(id);
      e.sum = s[4:0];
      e.ovf = (s > 7) || (s < -8);
      return e;
   endfunction

   // Response scoreboard and overflow-count model
   always @(negedge clk) begin
      exp_t e;
      if (cnt_chk_en && !rst) begin
         chk("ovf_count", 32'(bus.ovf_count), 32'(exp_cnt));
      end
      if (!rst && (bus.rsp_valid === 1'b1) && (bus.rsp_ready === 1'b1)) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp: id %0d sum %b, required no response", bus.rsp_id, bus.rsp_sum);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            chk("rsp_sum", 32'(bus.rsp_sum), 32'(e.sum));
            chk("rsp_overflow", 32'(bus.rsp_overflow), 32'(e.ovf));
            if (e.ovf && (exp_cnt != 8'hFF)) exp_cnt = exp_cnt + 8'd1;
         end
      end
   end

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0) && (n < budget)) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      cnt_chk_en = 1'b0;
      rst = 1'b1;
      bus.req_valid = 4'b0000;
      tick();
      tick();
      rst = 1'b0;
      exp_cnt = 8'd0;
      exp_q.delete();
      cnt_chk_en = 1'b1;
   endtask

   // Single-requester operation: grant, latency and (optionally) drain of the result
   task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [4:0] es, input logic eo, input bit drain);
      int n;
      bus.req_valid = 4'b0001 << id;
      bus.req_a[id*4 +: 4] = a;
      bus.req_b[id*4 +: 4] = b;
      #1;
      n = 0;
      while ((bus.req_ready[id] !== 1'b1) && (n < 20)) begin
         tick();
         n++;
      end
      chk("grant", 32'(bus.req_ready), 32'(4'b0001 << id));
      exp_q.push_back('{2'(id), es, eo});
      tick();
      bus.req_valid = 4'b0000;
      bus.req_a = 16'($urandom);
      bus.req_b = 16'($urandom);
      chk("lat_exec", 32'(bus.rsp_valid), 32'd0);
      tick();
      chk("lat_resp", 32'(bus.rsp_valid), 32'd1);
      if (drain) wait_drain(20);
   endtask

   vec_t       vecs[10];
   logic [3:0] ta[4];
   logic [3:0] tb_b[4];
   int         order[5];
   int         last_cyc;
   int         n;
   exp_t       e;

   initial begin
      n_chk = 0;
      n_fail = 0;
      cyc = 0;
      exp_cnt = 8'd0;
      cnt_chk_en = 1'b0;
      rst = 1'b1;
      bus.req_valid = 4'b0000;
      bus.req_a = 16'h0000;
      bus.req_b = 16'h0000;
      bus.rsp_ready = 1'b1;

      vecs[0] = '{0, 4'h7, 4'h1, 5'b01000, 1'b1};
      vecs[1] = '{1, 4'h8, 4'hE, 5'b10110, 1'b1};
      vecs[2] = '{2, 4'h5, 4'hB, 5'b00000, 1'b0};
      vecs[3] = '{3, 4'hD, 4'hD, 5'b11010, 1'b0};
      vecs[4] = '{0, 4'h8, 4'h7, 5'b11111, 1'b0};
      vecs[5] = '{2, 4'h8, 4'h8, 5'b10000, 1'b1};
      vecs[6] = '{1, 4'h7, 4'h7, 5'b01110, 1'b1};
      vecs[7] = '{3, 4'hF, 4'hF, 5'b11110, 1'b0};
      vecs[8] = '{0, 4'hC, 4'hC, 5'b11000, 1'b0};
      vecs[9] = '{3, 4'h3, 4'h4, 5'b00111, 1'b0};

      // Reset state
      do_reset();
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
      chk("rst_rsp_overflow", 32'(bus.rsp_overflow), 32'd0);
      chk("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);

      // Vector table
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].ovf, 1'b1);
         if (i == 0) chk("first_ovf_count", 32'(bus.ovf_count), 32'd1);
      end

      // All four requesting: strict rotation, one accept every 3 cycles
      do_reset();
      ta[0] = 4'h7; tb_b[0] = 4'h7;
      ta[1] = 4'h8; tb_b[1] = 4'h1;
      ta[2] = 4'h4; tb_b[2] = 4'hA;
      ta[3] = 4'h8; tb_b[3] = 4'h8;
      order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 4; i++) begin
         bus.req_a[i*4 +: 4] = ta[i];
         bus.req_b[i*4 +: 4] = tb_b[i];
      end
      bus.req_valid = 4'b1111;
      #1;
      last_cyc = 0;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         while ((bus.req_ready == 4'b0000) && (n < 10)) begin
            tick();
            n++;
         end
         chk("rr_grant", 32'(bus.req_ready), 32'(4'b0001 << order[k]));
         if (k > 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'd3);
         last_cyc = cyc;
         exp_q.push_back(model(order[k], ta[order[k]], tb_b[order[k]]));
         tick();
      end
      bus.req_valid = 4'b0000;
      wait_drain(20);

      // Back-pressure: response held for 5 cycles, no grants meanwhile
      bus.rsp_ready = 1'b0;
      run_op(1, 4'h6, 4'h1, 5'b00111, 1'b0, 1'b0);
      bus.req_a[8 +: 4] = 4'h2;
      bus.req_b[8 +: 4] = 4'h3;
      bus.req_valid = 4'b0100;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("hold_sum", 32'(bus.rsp_sum), 32'(5'b00111));
         chk("hold_id", 32'(bus.rsp_id), 32'd1);
         chk("hold_ready", 32'(bus.req_ready), 32'd0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      chk("resume_grant", 32'(bus.req_ready), 32'(4'b0100));
      exp_q.push_back('{2'd2, 5'b00101, 1'b0});
      tick();
      bus.req_valid = 4'b0000;
      wait_drain(20);

      // Reset during EXEC: operation discarded, counter cleared, priority back to 0
      ta[0] = 4'h5; tb_b[0] = 4'h6;
      bus.req_a[0 +: 4] = ta[0];
      bus.req_b[0 +: 4] = tb_b[0];
      bus.req_a[4 +: 4] = 4'h7;
      bus.req_b[4 +: 4] = 4'h7;
      bus.req_valid = 4'b0010;
      #1;
      chk("pre_rst_grant", 32'(bus.req_ready), 32'(4'b0010));
      tick();
      cnt_chk_en = 1'b0;
      rst = 1'b1;
      bus.req_valid = 4'b0000;
      tick();
      chk("rst_exec_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_exec_count", 32'(bus.ovf_count), 32'd0);
      rst = 1'b0;
      exp_cnt = 8'd0;
      exp_q.delete();
      cnt_chk_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);
         tick();
      end
      bus.req_valid = 4'b1111;
      #1;
      chk("post_rst_grant", 32'(bus.req_ready), 32'(4'b0001));
      e = model(0, ta[0], tb_b[0]);
      exp_q.push_back(e);
      tick();
      bus.req_valid = 4'b0000;
      wait_drain(20);

      // Saturation of the overflow counter
      do_reset();
      for (int i = 0; i < 260; i++) begin
         run_op(0, 4'h7, 4'h7, 5'b01110, 1'b1, 1'b1);
      end
      chk("ovf_saturated", 32'(bus.ovf_count), 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
